cbus_arbiter: RTL and testbench

Parametrised N-input arbiter for the cached-bus (CBus) path, sharing one `cbus_req_t`/`cbus_resp_t` port to memory among NUM_INPUTS requesters such as the instruction-side and data-side bus converters. It sits between the converters and the top-level memory port, in place of the pass-through multiplexer. It grants one requester per transaction and holds the grant until the final beat of a burst completes. Fixed-priority or round-robin selection is chosen at compile time.

---
 rtl/cbus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_cbus_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
// ---------------------------------------------------------------------------
// cbus_arbiter_pkg / cbus_arbiter
//
// Purpose: shares one cached-bus (CBus) memory port among NUM_INPUTS
// requesters (e.g. instruction-side and data-side bus converters). One
// requester is granted per transaction and the grant is held until the final
// beat of the burst (oresp.ready && oresp.last) completes. A one-cycle idle
// bubble always separates consecutive transactions.
//
// Build option:
//   CBUS_ARB_RR_EN defined   : round-robin selection from a registered pointer
//   CBUS_ARB_RR_EN undefined : fixed priority, index 0 highest
//
// Ports:
//   clk        system clock, rising edge
//   resetn     synchronous active-low reset
//   ireqs      per-requester requests (packed array, index 0 = highest prio)
//   iresps     per-requester responses; only the granted entry is non-zero
//   oreq       request to memory (pass-through of the granted request)
//   oresp      response from memory
//   busy       high while a grant is held
//   grant_idx  index of the current grant, 0 when idle
// ---------------------------------------------------------------------------

package cbus_arbiter_pkg;

    localparam int unsigned CBUS_ADDR_W = 32;
    localparam int unsigned CBUS_DATA_W = 32;
    localparam int unsigned CBUS_LEN_W  = 8;
    localparam int unsigned CBUS_SIZE_W = 3;
    localparam int unsigned CBUS_STRB_W = CBUS_DATA_W / 8;

    // Request payload: len is beats-1, so len=0 is a single-beat transaction.
    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [CBUS_ADDR_W-1:0] addr;
        logic [CBUS_SIZE_W-1:0] size;
        logic [CBUS_LEN_W-1:0]  len;
        logic [CBUS_DATA_W-1:0] data;
        logic [CBUS_STRB_W-1:0] strobe;
    } cbus_req_t;

    // Response payload: ready marks a completed beat, last marks the final one.
    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

endpackage

module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_INPUTS = 2,
    localparam int unsigned IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  cbus_req_t  [NUM_INPUTS-1:0]      ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0]      iresps,
    output cbus_req_t                        oreq,
    input  cbus_resp_t                       oresp,
    output logic                             busy,
    output logic       [IDX_W-1:0]           grant_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] grant_d;
    logic [IDX_W-1:0] sel_idx;
    logic             any_valid;
    logic             last_beat;

    // Final beat of the granted burst completes at the coming edge.
    assign last_beat = oresp.ready & oresp.last;

`ifdef CBUS_ARB_RR_EN
    localparam int unsigned EXT_W = IDX_W + 1;

    logic [IDX_W-1:0] rr_ptr_q;
    logic [EXT_W-1:0] cand_ext;
    logic [IDX_W-1:0] cand;

    // Round-robin pick: first valid index scanning upward from the pointer.
    always_comb begin
        sel_idx   = '0;
        any_valid = 1'b0;
        cand_ext  = '0;
        cand      = '0;
        for (int k = 0; k < int'(NUM_INPUTS); k++) begin
            cand_ext = {1'b0, rr_ptr_q} + EXT_W'(k);
            if (cand_ext >= EXT_W'(NUM_INPUTS)) begin
                cand_ext = cand_ext - EXT_W'(NUM_INPUTS);
            end
            cand = cand_ext[IDX_W-1:0];
            if (!any_valid && ireqs[cand].valid) begin
                any_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Pointer moves past the requester whose burst just finished.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr_q <= '0;
        end else if (state_q == ST_BUSY && last_beat) begin
            rr_ptr_q <= (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
        end
    end
`else
    // Fixed-priority pick: lowest valid index wins.
    always_comb begin
        sel_idx   = '0;
        any_valid = 1'b0;
        for (int k = 0; k < int'(NUM_INPUTS); k++) begin
            if (!any_valid && ireqs[k].valid) begin
                any_valid = 1'b1;
                sel_idx   = IDX_W'(k);
            end
        end
    end
`endif

    // State and grant registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Next-state and datapath steering; the grant is frozen while BUSY.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        oreq    = '0;
        iresps  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    state_d = ST_BUSY;
                    grant_d = sel_idx;
                end
            end
            ST_BUSY: begin
                oreq            = ireqs[grant_q];
                iresps[grant_q] = oresp;
                if (last_beat) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign busy      = (state_q == ST_BUSY);
    assign grant_idx = grant_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cbus_arbiter: scoreboard bench for cbus_arbiter with four requesters.
// Each scenario pushes the grant order it expects; a timing model of the
// handshake pops that order when a transaction should start, and every cycle
// the DUT outputs are compared with the expected routing.
// ---------------------------------------------------------------------------
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [31:0]   addr;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 resetn;
    cbus_req_t  [N-1:0]   ireqs;
    cbus_resp_t [N-1:0]   iresps;
    cbus_req_t            oreq;
    cbus_resp_t           oresp;
    logic                 busy;
    logic [IW-1:0]        grant_idx;

    always #5 clk = ~clk;

    cbus_arbiter #(.NUM_INPUTS(N)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ireqs     (ireqs),
        .iresps    (iresps),
        .oreq      (oreq),
        .oresp     (oresp),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Requester side: per-input request queues and progress tracking.
    cbus_req_t rq [N][$];
    int        drop_at [N];
    int        beats [N];
    bit        done [N];
    exp_t      exp_q [$];

    // Requesters update just after the edge: retire, drop mid-burst, or load.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < int'(N); i++) begin
            if (done[i]) begin
                ireqs[i] = '0;
                done[i]  = 1'b0;
            end else if (ireqs[i].valid && drop_at[i] >= 0 && beats[i] >= drop_at[i]) begin
                ireqs[i].valid = 1'b0;
                drop_at[i]     = -1;
            end
            if (!ireqs[i].valid && ireqs[i].addr == '0 && rq[i].size() > 0) begin
                ireqs[i] = rq[i].pop_front();
                beats[i] = 0;
            end
        end
    end

    // Requesters observe their response beats mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < int'(N); i++) begin
            if (iresps[i].ready === 1'b1) begin
                beats[i]++;
                if (iresps[i].last === 1'b1) done[i] = 1'b1;
            end
        end
    end

    // Memory model: latches the request on its first cycle, one beat per cycle.
    bit          mem_active = 1'b0;
    bit          mem_spurious = 1'b0;
    bit          mem_rst;
    logic [31:0] mem_addr;
    logic [7:0]  mem_len;
    logic [7:0]  mem_beat;

    always @(posedge clk) begin
        mem_rst = (resetn !== 1'b1);
        #2;
        if (mem_rst) begin
            mem_active = 1'b0;
            oresp      = '0;
        end else begin
            if (!mem_active && oreq.valid === 1'b1) begin
                mem_active = 1'b1;
                mem_addr   = oreq.addr;
                mem_len    = oreq.len;
                mem_beat   = '0;
            end
            if (mem_active) begin
                oresp.ready = 1'b1;
                oresp.last  = (mem_beat == mem_len);
                oresp.data  = mem_addr + {24'h0, mem_beat};
                if (oresp.last) mem_active = 1'b0;
                else            mem_beat   = mem_beat + 8'd1;
            end else if (mem_spurious) begin
                oresp = {1'b1, 1'b1, 32'hdead_beef};
            end else begin
                oresp = '0;
            end
        end
    end

    // Handshake timing model: grant one edge after any valid in idle,
    // release at the final beat, order taken from the scoreboard queue.
    logic          m_busy  = 1'b0;
    logic          m_start = 1'b0;
    logic [IW-1:0] m_idx   = '0;
    logic [31:0]   m_addr  = '0;
    exp_t          e_pop;
    logic          any_req;

    always @(posedge clk) begin
        any_req = 1'b0;
        for (int i = 0; i < int'(N); i++) any_req = any_req | ireqs[i].valid;
        m_start <= 1'b0;
        if (!resetn) begin
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            if (any_req) begin
                check("sb_pop", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e_pop = exp_q.pop_front();
                    m_idx  <= e_pop.idx;
                    m_addr <= e_pop.addr;
                end
                m_busy  <= 1'b1;
                m_start <= 1'b1;
            end
        end else if (oresp.ready && oresp.last) begin
            m_busy <= 1'b0;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 128'(busy), 128'(m_busy));
            check("grant_idx", 128'(grant_idx), 128'(m_busy ? m_idx : '0));
            check("oreq", 128'(oreq), 128'(m_busy ? ireqs[m_idx] : '0));
            if (m_start) check("start_addr", 128'(oreq.addr), 128'(m_addr));
            for (int i = 0; i < int'(N); i++) begin
                check($sformatf("iresp%0d", i), 128'(iresps[i]),
                      128'((m_busy && m_idx == IW'(i)) ? oresp : '0));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_req(input int i, input logic [31:0] addr, input logic [7:0] len);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = addr[12];
        r.addr     = addr;
        r.size     = 3'd2;
        r.len      = len;
        r.data     = ~addr;
        r.strobe   = 4'hf;
        rq[i].push_back(r);
    endtask

    task automatic expect_grant(input int i, input logic [31:0] addr);
        exp_t e;
        e.idx  = IW'(i);
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        bit pending;
        for (int n = 0; n < budget; n++) begin
            pending = m_busy || (exp_q.size() != 0);
            for (int i = 0; i < int'(N); i++) pending = pending || ireqs[i].valid || (rq[i].size() != 0);
            if (!pending) break;
            tick(1);
        end
        check(tag, 128'(pending), 128'(0));
    endtask

    function automatic logic [31:0] rr_addr(input int i, input int r);
        return 32'h5000 + 32'(i) * 32'h100 + 32'(r) * 32'h10;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        ireqs  = '0;
        for (int i = 0; i < int'(N); i++) begin
            drop_at[i] = -1;
            beats[i]   = 0;
            done[i]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
        resetn = 1'b1;
        mon_en = 1'b1;

        // Idle after reset, then memory ready/last while idle must be ignored.
        tick(20);
        mem_spurious = 1'b1;
        tick(3);
        mem_spurious = 1'b0;
        tick(2);

        // Single 4-beat read from input 1.
        push_req(1, 32'h0000_0100, 8'd3);
        expect_grant(1, 32'h0000_0100);
        wait_drain("drain_single", 60);

        // Simultaneous requests from inputs 0 and 1.
        push_req(0, 32'h0000_2000, 8'd1);
        push_req(1, 32'h0000_3000, 8'd2);
        expect_grant(0, 32'h0000_2000);
        expect_grant(1, 32'h0000_3000);
        wait_drain("drain_simul", 60);

        // Lone request from input 3 (leaves the RR pointer at 0).
        push_req(3, 32'h0000_4000, 8'd0);
        expect_grant(3, 32'h0000_4000);
        wait_drain("drain_lone3", 30);

        // All four inputs continuously valid with single-beat transfers.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < int'(N); i++) push_req(i, rr_addr(i, r), 8'd0);
`ifdef CBUS_ARB_RR_EN
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < int'(N); i++) expect_grant(i, rr_addr(i, r));
`else
        for (int i = 0; i < int'(N); i++)
            for (int r = 0; r < 2; r++) expect_grant(i, rr_addr(i, r));
`endif
        wait_drain("drain_fair", 80);

        // Grant hold: input 1 drops valid during beat 1 while input 2 waits.
        drop_at[1] = 1;
        push_req(1, 32'h0000_6000, 8'd3);
        push_req(2, 32'h0000_7000, 8'd1);
        expect_grant(1, 32'h0000_6000);
        expect_grant(2, 32'h0000_7000);
        wait_drain("drain_hold", 60);

        // Reset in the middle of input 2's burst with inputs 1 and 3 pending.
        push_req(2, 32'h0000_8000, 8'd3);
        expect_grant(2, 32'h0000_8000);
        for (int n = 0; n < 10 && !m_busy; n++) tick(1);
        check("rst_pre_grant", 128'(m_busy), 128'(1));
        push_req(1, 32'h0000_9000, 8'd0);
        push_req(3, 32'h0000_a000, 8'd0);
        expect_grant(1, 32'h0000_9000);
        expect_grant(2, 32'h0000_8000);
        expect_grant(3, 32'h0000_a000);
        for (int n = 0; n < 20 && beats[2] < 3; n++) tick(1);
        check("rst_beats", 128'(beats[2] >= 3), 128'(1));
        resetn = 1'b0;
        tick(1);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_oreq_valid", 128'(oreq.valid), 128'(0));
        check("rst_grant_idx", 128'(grant_idx), 128'(0));
        resetn = 1'b1;
        wait_drain("drain_reset", 80);

        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
